// File: rtl/rx_ack_gen_engine_if.sv
// Segment-descriptor, flow-init and ACK-request signals between the RX pipeline and the ACK generator.
interface rx_ack_gen_engine_if #(
    parameter int ACK_NUM_W     = 32,
    parameter int PAYLOAD_LEN_W = 16
);
    logic                     flow_init_val;
    logic [ACK_NUM_W-1:0]     flow_init_rcv_nxt;
    logic                     seg_val;
    logic                     seg_rdy;
    logic [ACK_NUM_W-1:0]     seg_seq_num;
    logic [PAYLOAD_LEN_W-1:0] seg_payload_len;
    logic [PAYLOAD_LEN_W:0]   rx_buf_free;
    logic                     seg_accept;
    logic                     ack_req_val;
    logic                     ack_req_rdy;
    logic [ACK_NUM_W-1:0]     ack_req_num;
    logic                     ack_req_dup;
    logic [ACK_NUM_W-1:0]     rcv_nxt;

    modport slave (
        input  flow_init_val, flow_init_rcv_nxt,
        input  seg_val, seg_seq_num, seg_payload_len, rx_buf_free,
        input  ack_req_rdy,
        output seg_rdy, seg_accept,
        output ack_req_val, ack_req_num, ack_req_dup, rcv_nxt
    );

    modport master (
        output flow_init_val, flow_init_rcv_nxt,
        output seg_val, seg_seq_num, seg_payload_len, rx_buf_free,
        output ack_req_rdy,
        input  seg_rdy, seg_accept,
        input  ack_req_val, ack_req_num, ack_req_dup, rcv_nxt
    );
endinterface

// File: rtl/rx_ack_gen_engine.sv
// RX ACK generator: tracks rcv_nxt, raises delayed / every-N / duplicate ACK requests one cycle after the trigger.
// Segment side never stalls; an ACK request is held stable until ack_req_rdy.
module rx_ack_gen_engine #(
    parameter int ACK_NUM_W     = 32,
    parameter int PAYLOAD_LEN_W = 16,
    parameter int ACK_EVERY_N   = 2,
    parameter int DELAY_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    rx_ack_gen_engine_if.slave bus
);
    localparam int CNT_W = $clog2(ACK_EVERY_N + 1);
    localparam int TMR_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(ACK_EVERY_N);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(DELAY_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t               state;
    logic [ACK_NUM_W-1:0] rcv_q;
    logic [ACK_NUM_W-1:0] num_q;
    logic [ACK_NUM_W-1:0] rcv_upd;
    logic [CNT_W-1:0]     pend_cnt;
    logic [CNT_W-1:0]     pend_sat;
    logic [CNT_W:0]       pend_sum;
    logic [TMR_W-1:0]     timer;
    logic                 imm_flag;
    logic                 val_q;
    logic                 dup_q;
    logic                 accept_q;
    logic                 seg_has_data;
    logic                 in_order;
    logic                 imm;
    logic                 count_hit;
    logic                 handshake;
    logic                 fire;

    // flow_init_val masks the segment so a reload cycle never accepts or triggers.
    assign seg_has_data = bus.seg_val & ~bus.flow_init_val & (bus.seg_payload_len != '0);
    assign in_order     = seg_has_data & (bus.seg_seq_num == rcv_q)
                        & ({1'b0, bus.seg_payload_len} <= bus.rx_buf_free);
    assign imm          = seg_has_data & ~in_order;
    assign rcv_upd      = in_order ? rcv_q + ACK_NUM_W'(bus.seg_payload_len) : rcv_q;

    assign pend_sum  = {1'b0, pend_cnt} + {{CNT_W{1'b0}}, in_order};
    assign count_hit = (pend_sum >= CNT_LIMIT);
    assign pend_sat  = count_hit ? CNT_LIMIT[CNT_W-1:0] : pend_sum[CNT_W-1:0];
    assign handshake = val_q & bus.ack_req_rdy;

    always_comb begin
        fire = 1'b0;
        case (state)
            IDLE:    fire = imm | count_hit;
            DELAY:   fire = imm | count_hit | (timer == TMR_W'(1));
            SEND:    fire = handshake & (imm_flag | imm);
            default: fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rcv_q    <= '0;
            num_q    <= '0;
            val_q    <= 1'b0;
            dup_q    <= 1'b0;
            accept_q <= 1'b0;
            pend_cnt <= '0;
            timer    <= '0;
            imm_flag <= 1'b0;
        end else begin
            accept_q <= in_order;
            if (bus.flow_init_val) begin
                rcv_q    <= bus.flow_init_rcv_nxt;
                state    <= IDLE;
                val_q    <= 1'b0;
                pend_cnt <= '0;
                timer    <= '0;
                imm_flag <= 1'b0;
            end else begin
                rcv_q <= rcv_upd;
                if (fire) begin
                    // Captured number includes this cycle's in-order advance.
                    state    <= SEND;
                    val_q    <= 1'b1;
                    num_q    <= rcv_upd;
                    dup_q    <= imm | (state == SEND);
                    pend_cnt <= '0;
                    imm_flag <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (in_order) begin
                                state    <= DELAY;
                                timer    <= TMR_LOAD;
                                pend_cnt <= pend_sat;
                            end
                        end
                        DELAY: begin
                            timer    <= timer - TMR_W'(1);
                            pend_cnt <= pend_sat;
                        end
                        SEND: begin
                            if (handshake) begin
                                val_q <= 1'b0;
                                if (pend_sum != '0) begin
                                    state    <= DELAY;
                                    timer    <= TMR_LOAD;
                                    pend_cnt <= pend_sat;
                                end else begin
                                    state    <= IDLE;
                                    pend_cnt <= '0;
                                end
                            end else begin
                                pend_cnt <= pend_sat;
                                imm_flag <= imm_flag | imm;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.seg_rdy     = ~rst;
    assign bus.seg_accept  = accept_q;
    assign bus.ack_req_val = val_q;
    assign bus.ack_req_num = num_q;
    assign bus.ack_req_dup = dup_q;
    assign bus.rcv_nxt     = rcv_q;
endmodule

// File: doc/rx_ack_gen_engine.md
Name: rx_ack_gen_engine

Overview:
Receive-side ACK generator for one TCP flow; the counterpart to the TX ACK processing on incoming packets. It tracks the next expected receive sequence number (rcv_nxt) from segments delivered by the receive pipeline. It decides when an ACK must go out: delayed-ACK timer, every-N-segments rule, or immediate duplicate ACK on out-of-order or rejected data. It then issues ACK requests to the transmit pipeline over a valid/ready handshake.

Parameters:
ACK_NUM_W, 32, width of sequence/ACK numbers
PAYLOAD_LEN_W, 16, width of segment payload length
ACK_EVERY_N, 2, in-order segments that force an ACK
DELAY_CYCLES, 1024, delayed-ACK timeout in clocks (must be >=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flow_init_val  in  1  load initial receive sequence number
flow_init_rcv_nxt  in  ACK_NUM_W  initial rcv_nxt (peer ISN+1)
seg_val  in  1  incoming segment descriptor valid
seg_rdy  out  1  always 1 out of reset; 0 while rst asserted
seg_seq_num  in  ACK_NUM_W  segment sequence number
seg_payload_len  in  PAYLOAD_LEN_W  payload bytes (0 = pure ACK/control)
rx_buf_free  in  PAYLOAD_LEN_W+1  free bytes in receive payload buffer
seg_accept  out  1  1-cycle pulse: segment data accepted into buffer
ack_req_val  out  1  ACK request to TX pipeline
ack_req_rdy  in  1  TX pipeline accepts request
ack_req_num  out  ACK_NUM_W  ACK number to send; stable while ack_req_val
ack_req_dup  out  1  request caused by out-of-order/rejected segment
rcv_nxt  out  ACK_NUM_W  current next expected sequence number

Behaviour:
- Reset values: rcv_nxt=0, ack_req_val=0, ack_req_num=0, ack_req_dup=0, seg_accept=0, state=IDLE, pend_cnt=0, timer=0, imm_flag=0.
- A segment is taken when seg_val is high (seg_rdy is high). Classification happens in the same cycle:
  - len==0: ignored. No rcv_nxt change, no ACK trigger.
  - in-order: seq==rcv_nxt, len>0, len<=rx_buf_free. Next cycle rcv_nxt=rcv_nxt+len mod 2^ACK_NUM_W, seg_accept pulses, pend_cnt increments (saturating at ACK_EVERY_N).
  - out-of-order: seq!=rcv_nxt, len>0. Also covers an in-order segment with len>rx_buf_free. rcv_nxt unchanged, no seg_accept. Raises an immediate trigger (imm).
- Sequence comparison is equality only. Wraparound is handled purely by modular addition.
- FSM:
  - IDLE: on in-order -> DELAY, timer=DELAY_CYCLES. On imm -> SEND.
  - DELAY: timer decrements every cycle. Go to SEND when timer reaches 1, or pend_cnt+this cycle's in-order reaches ACK_EVERY_N, or imm.
  - SEND: on entry capture ack_req_num = rcv_nxt as of that cycle, including that cycle's in-order update. Capture ack_req_dup = (entry caused by imm). ack_req_val=1. Outputs are held stable until ack_req_val && ack_req_rdy.
  - In SEND, in-order segments update rcv_nxt and count into a post-send pend_cnt; an imm sets imm_flag.
  - On handshake: if imm_flag or imm this cycle -> SEND again, recapturing the current rcv_nxt. Else if post-send pend_cnt>0 (including a same-cycle accept) -> DELAY with a reloaded timer. Else -> IDLE with pend_cnt=0.
  - Entering SEND clears pend_cnt, except for segments accepted during SEND.
- Latency: with ACK_EVERY_N reached or imm in cycle T, ack_req_val is asserted in cycle T+1. Timer path: ack_req_val is asserted DELAY_CYCLES cycles after the first in-order accept.
- flow_init_val has priority over everything in its cycle:
  - rcv_nxt=flow_init_rcv_nxt.
  - FSM->IDLE; pend_cnt, timer and imm_flag cleared.
  - An outstanding ack_req_val drops without a handshake.
  - Any seg_val in that cycle is ignored.
- Async reset mid-SEND drops ack_req_val immediately.

Test Plan:
- Init rcv_nxt=1000, ACK_EVERY_N=2. Segments (1000,100) and (1100,200) on consecutive cycles -> ack_req_val one cycle after the second. ack_req_num=1300, ack_req_dup=0. rcv_nxt=1300.
- Single segment (1000,50), ack_req_rdy held 1 -> ack_req_val asserts exactly DELAY_CYCLES cycles after accept, ack_req_num=1050. FSM IDLE after handshake.
- rcv_nxt=1000, segment (1500,100) -> no seg_accept. Next cycle ack_req_val, ack_req_num=1000, ack_req_dup=1. rcv_nxt stays 1000.
- Wraparound: init rcv_nxt=0xFFFF_FFF0, segment (0xFFFF_FFF0,32) -> rcv_nxt=0x0000_0010. The ACK carries 0x10.
- ack_req_rdy=0 for 5 cycles in SEND while in-order (1300,100) arrives -> ack_req_num stays 1300 throughout. After the handshake FSM goes to DELAY, and the later ACK carries 1400.
- rx_buf_free=50, in-order segment len 100 -> rejected, immediate dup ACK with rcv_nxt unchanged. flow_init_val asserted during SEND -> ack_req_val low the next cycle, rcv_nxt reloaded.
